// File: rtl/data_sram_req_ctrl.sv
// Data-side SRAM-like request issuer: latches one EXE load/store, issues it, and returns the response to MEM.
// Optional misaligned-address exception check is enabled by defining DSRAM_ALE_CHECK_EN.
module data_sram_req_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              exe_req_valid,
  input  logic              exe_req_wr,
  input  logic [1:0]        exe_req_size,
  input  logic [ADDR_W-1:0] exe_req_addr,
  input  logic [DATA_W-1:0] exe_req_wdata,
  output logic              exe_req_accept,
  input  logic              flush,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              resp_ready,
  output logic              busy,
  output logic              ale,
  output logic [ADDR_W-1:0] ale_badv
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t              state_reg, state_next;
  logic                cancel_reg, cancel_next;
  logic                wr_reg;
  logic [1:0]          size_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [3:0]          wstrb_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   buf_reg;
  logic                buf_load;
  logic [1:0]          size_norm;
  logic [3:0]          wstrb_calc;
  logic [DATA_W-1:0]   wdata_calc;
  logic                can_issue;

  // Size 3 is illegal and is handled as a word access throughout.
  assign size_norm = (exe_req_size == 2'd3) ? 2'd2 : exe_req_size;
  assign can_issue = resetn & (state_reg == IDLE) & exe_req_valid & ~flush;

`ifdef DSRAM_ALE_CHECK_EN
  logic misaligned;
  assign misaligned = ((size_norm == 2'd1) & exe_req_addr[0]) |
                      ((size_norm == 2'd2) & (exe_req_addr[1:0] != 2'b00));
  assign exe_req_accept = can_issue & ~misaligned;
  assign ale            = can_issue & misaligned;
  assign ale_badv       = ale ? exe_req_addr : '0;
`else
  assign exe_req_accept = can_issue;
  assign ale            = 1'b0;
  assign ale_badv       = '0;
`endif

  always_comb begin
    wstrb_calc = 4'b0000;
    wdata_calc = exe_req_wdata;
    case (size_norm)
      2'd0: begin
        wstrb_calc = 4'b0001 << exe_req_addr[1:0];
        wdata_calc = {(DATA_W/8){exe_req_wdata[7:0]}};
      end
      2'd1: begin
        wstrb_calc = 4'b0011 << {exe_req_addr[1], 1'b0};
        wdata_calc = {(DATA_W/16){exe_req_wdata[15:0]}};
      end
      default: wstrb_calc = 4'b1111;
    endcase
    if (!exe_req_wr) wstrb_calc = 4'b0000;
  end

  always_comb begin
    state_next  = state_reg;
    cancel_next = cancel_reg;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    buf_load    = 1'b0;
    case (state_reg)
      IDLE: if (exe_req_accept) state_next = REQ;
      REQ: begin
        // The request is never retracted; a flush only marks the op for discard.
        if (flush) cancel_next = 1'b1;
        if (data_sram_addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (flush) cancel_next = 1'b1;
        if (data_sram_data_ok) begin
          if (cancel_reg || flush) begin
            state_next = IDLE;
          end else begin
            resp_valid = 1'b1;
            resp_rdata = data_sram_rdata;
            if (resp_ready) begin
              state_next = IDLE;
            end else begin
              state_next = HOLD;
              buf_load   = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          resp_valid = 1'b1;
          resp_rdata = buf_reg;
          if (resp_ready) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) cancel_next = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cancel_reg <= 1'b0;
      wr_reg     <= 1'b0;
      size_reg   <= 2'd0;
      addr_reg   <= '0;
      wstrb_reg  <= 4'b0000;
      wdata_reg  <= '0;
      buf_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      cancel_reg <= cancel_next;
      if (exe_req_accept) begin
        wr_reg    <= exe_req_wr;
        size_reg  <= size_norm;
        addr_reg  <= exe_req_addr;
        wstrb_reg <= wstrb_calc;
        wdata_reg <= wdata_calc;
      end
      if (buf_load) buf_reg <= data_sram_rdata;
    end
  end

  assign data_sram_req   = (state_reg == REQ);
  assign data_sram_wr    = wr_reg;
  assign data_sram_size  = size_reg;
  assign data_sram_addr  = addr_reg;
  assign data_sram_wstrb = wstrb_reg;
  assign data_sram_wdata = wdata_reg;
  assign busy            = (state_reg != IDLE);

endmodule
